packet_arbiter: RTL and testbench

PACKET_ARBITER -- requirements
Module: packet_arbiter

---
 rtl/packet_arbiter_pkg.sv | 15 +
 rtl/packet_arbiter_reg.sv | 22 ++
 rtl/packet_arbiter_rr_pick.sv | 31 +++
 rtl/packet_arbiter.sv | 159 +++++++++++++++
 tb/tb_packet_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_arbiter_pkg.sv
// Shared definitions for the packet arbiter: FSM state encoding and
// default sizing of the requester count, length field and flit payload.
package packet_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADD_WIDTH  = 8;
  localparam int DEF_FLIT_WIDTH = 32;

endpackage

// File: rtl/packet_arbiter_reg.sv
// Generic load-enable register with asynchronous active-high reset to a
// parameterised value.
module packet_arbiter_reg #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/packet_arbiter_rr_pick.sv
// Combinational round-robin search: first requester above last_ptr,
// wrapping around, returned both one-hot and as an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  int   cand;
  logic found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_ptr) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// Round-robin packet arbiter: grants one source the injection port for a
// whole packet (head flit plus flit_length data flits) before re-arbitrating.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int FLIT_WIDTH = DEF_FLIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADD_WIDTH-1:0]  flit_length_i,
  input  logic [NUM_REQ*8-1:0]          flit_address_i,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] flit_data_i,
  input  logic                          out_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            pop_o,
  output logic                          out_valid_o,
  output logic [FLIT_WIDTH-1:0]         out_data_o,
  output logic [7:0]                    flit_address_o,
  output logic [ADD_WIDTH-1:0]          remaining_o,
  output logic                          busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_ptr_q, last_ptr_d;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 transfer;
  logic                 req_sel;
  logic [ADD_WIDTH-1:0] len_sel;
  logic [7:0]           addr_sel;
  logic [FLIT_WIDTH-1:0] data_sel;
  logic                 rem_en, addr_en;
  logic [ADD_WIDTH-1:0] rem_d;

  // Counter never wraps below zero, even if asked to decrement at 0.
  function automatic logic [ADD_WIDTH-1:0] dec_sat(input logic [ADD_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - ADD_WIDTH'(1);
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req_i),
    .last_ptr (last_ptr_q),
    .onehot   (pick_onehot),
    .idx      (pick_idx)
  );

  always_comb begin
    len_sel  = '0;
    addr_sel = '0;
    data_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx_q == IDX_W'(k)) begin
        len_sel  = flit_length_i[k*ADD_WIDTH +: ADD_WIDTH];
        addr_sel = flit_address_i[k*8 +: 8];
        data_sel = flit_data_i[k*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign req_sel     = |(req_i & grant_q);
  assign out_valid_o = busy_o && req_sel;
  assign out_data_o  = busy_o ? data_sel : '0;
  assign transfer    = out_valid_o && out_ready_i;
  assign pop_o       = transfer ? grant_q : '0;
  assign grant_o     = grant_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    last_ptr_d = last_ptr_q;
    rem_en     = 1'b0;
    rem_d      = remaining_o;
    addr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (transfer) begin
          rem_en  = 1'b1;
          rem_d   = len_sel;
          addr_en = 1'b1;
          state_d = BODY;
          if (len_sel == '0) begin
            state_d    = IDLE;
            grant_d    = '0;
            last_ptr_d = idx_q;
          end
        end
      end
      BODY: begin
        if (transfer) begin
          rem_en = 1'b1;
          rem_d  = dec_sat(remaining_o);
          if (remaining_o <= ADD_WIDTH'(1)) begin
            state_d    = IDLE;
            grant_d    = '0;
            last_ptr_d = idx_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      last_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  packet_arbiter_reg #(
    .W (ADD_WIDTH)
  ) u_remaining (
    .clk (clk),
    .rst (rst),
    .en  (rem_en),
    .d   (rem_d),
    .q   (remaining_o)
  );

  packet_arbiter_reg #(
    .W (8)
  ) u_address (
    .clk (clk),
    .rst (rst),
    .en  (addr_en),
    .d   (addr_sel),
    .q   (flit_address_o)
  );

endmodule

// File: tb/tb_packet_arbiter.sv
// Self-checking bench for packet_arbiter: directed scenarios plus random
// traffic, compared every cycle against a packet-level reference model.
module tb_packet_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int FW = 32;
  localparam int VW = N + N + 1 + FW + 8 + AW + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic            ready = 1'b1;
  logic [AW-1:0]   len_a [N];
  logic [7:0]      adr_a [N];
  logic [FW-1:0]   dat_a [N];
  logic [N*AW-1:0] len_flat;
  logic [N*8-1:0]  adr_flat;
  logic [N*FW-1:0] dat_flat;

  logic [N-1:0]    grant_o, pop_o;
  logic            out_valid_o, busy_o;
  logic [FW-1:0]   out_data_o;
  logic [7:0]      flit_address_o;
  logic [AW-1:0]   remaining_o;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign len_flat[k*AW +: AW] = len_a[k];
    assign adr_flat[k*8 +: 8]   = adr_a[k];
    assign dat_flat[k*FW +: FW] = dat_a[k];
  end

  packet_arbiter #(.NUM_REQ(N), .ADD_WIDTH(AW), .FLIT_WIDTH(FW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .flit_length_i  (len_flat),
    .flit_address_i (adr_flat),
    .flit_data_i    (dat_flat),
    .out_ready_i    (ready),
    .grant_o        (grant_o),
    .pop_o          (pop_o),
    .out_valid_o    (out_valid_o),
    .out_data_o     (out_data_o),
    .flit_address_o (flit_address_o),
    .remaining_o    (remaining_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which source owns the port, whether its head flit is
  // still pending, and how many data flits it still owes.
  int          m_owner;
  bit          m_head_pending;
  int          m_owed;
  int          m_last;
  logic [7:0]  m_addr;
  logic [VW-1:0] exp_vec;

  function automatic logic [VW-1:0] act_vec();
    return {grant_o, pop_o, out_valid_o, out_data_o, flit_address_o, remaining_o, busy_o};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_head_pending = 1'b0; m_owed = 0; m_last = N - 1; m_addr = '0;
  endtask

  task automatic eval_model();
    logic [N-1:0]  g;
    logic          v;
    logic [FW-1:0] d;
    #1;
    g = (m_owner < 0) ? '0 : N'(1 << m_owner);
    v = (m_owner >= 0) && req[m_owner];
    d = (m_owner >= 0) ? dat_a[m_owner] : '0;
    exp_vec = {g, (v && ready) ? g : N'(0), v, d, m_addr, AW'(m_owed), m_owner >= 0};
  endtask

  task automatic advance();
    bit xfer;
    bit found;
    @(posedge clk);
    xfer = (m_owner >= 0) && req[m_owner] && ready;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int s = 1; s <= N; s++) begin
        if (!found && req[(m_last + s) % N]) begin
          found = 1'b1; m_owner = (m_last + s) % N; m_head_pending = 1'b1;
        end
      end
    end else if (xfer) begin
      if (m_head_pending) begin
        m_head_pending = 1'b0;
        m_owed = int'(len_a[m_owner]);
        m_addr = adr_a[m_owner];
        if (m_owed == 0) begin m_last = m_owner; m_owner = -1; end
      end else begin
        m_owed = m_owed - 1;
        if (m_owed == 0) begin m_last = m_owner; m_owner = -1; end
      end
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) dat_a[k] = $urandom;
  endtask

  task automatic do_reset();
    req = '0; ready = 1'b1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    // Stir up some state, then assert reset mid-cycle.
    req = 4'b1111; for (int k = 0; k < N; k++) len_a[k] = 8'd3;
    for (int c = 0; c < 3; c++) advance();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (act_vec() !== '0) $display("FAIL reset_outputs: got %h want %h", act_vec(), {VW{1'b0}});
    else n_pass++;
    @(negedge clk); rst = 1'b0; req = '0;
    eval_model();
    n_checks++;
    if (act_vec() !== exp_vec) $display("FAIL reset_idle: got %h want %h", act_vec(), exp_vec);
    else n_pass++;
  endtask

  task automatic test_req1010();
    int order[$];
    logic [N-1:0] prev;
    do_reset();
    req = 4'b1010; len_a[1] = 8'd2; len_a[3] = 8'd0; adr_a[1] = 8'h11; adr_a[3] = 8'h33;
    prev = '0;
    for (int c = 0; c < 8; c++) begin
      eval_model();
      n_checks++;
      if (act_vec() !== exp_vec) $display("FAIL req1010_c%0d: got %h want %h", c, act_vec(), exp_vec);
      else n_pass++;
      if (grant_o != '0 && prev == '0) order.push_back(onehot_idx(grant_o));
      prev = grant_o;
      advance();
    end
    n_checks++;
    if (order.size() < 2 || order[0] != 1 || order[1] != 3)
      $display("FAIL req1010_order: got %p want 1 then 3", order);
    else n_pass++;
  endtask

  task automatic test_rr_order();
    int order[$];
    logic [N-1:0] prev;
    do_reset();
    req = 4'b1111; for (int k = 0; k < N; k++) len_a[k] = 8'd0;
    prev = '0;
    for (int c = 0; c < 11; c++) begin
      eval_model();
      n_checks++;
      if (act_vec() !== exp_vec) $display("FAIL rr_c%0d: got %h want %h", c, act_vec(), exp_vec);
      else n_pass++;
      if (grant_o != '0 && prev == '0) order.push_back(onehot_idx(grant_o));
      prev = grant_o;
      advance();
    end
    n_checks++;
    if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0)
      $display("FAIL rr_order: got %p want 0,1,2,3,0", order);
    else n_pass++;
  endtask

  task automatic test_ready_toggle();
    int pops;
    do_reset();
    req = 4'b0100; len_a[2] = 8'd5; adr_a[2] = 8'h22;
    pops = 0;
    for (int c = 0; c < 14; c++) begin
      ready = (c % 2 == 0);
      eval_model();
      n_checks++;
      if (act_vec() !== exp_vec) $display("FAIL ready_c%0d: got %h want %h", c, act_vec(), exp_vec);
      else n_pass++;
      if (pop_o[2]) pops++;
      advance();
    end
    n_checks++;
    if (pops != 6) $display("FAIL ready_pops: got %0d want 6", pops);
    else n_pass++;
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 4'b0100; len_a[2] = 8'd4; len_a[0] = 8'd1; ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c >= 3 && c <= 5) req = 4'b0001;
      else if (c >= 6) req = 4'b0101;
      eval_model();
      n_checks++;
      if (act_vec() !== exp_vec) $display("FAIL drop_c%0d: got %h want %h", c, act_vec(), exp_vec);
      else n_pass++;
      if (c >= 3 && c <= 5) begin
        n_checks++;
        if (grant_o !== 4'b0100 || pop_o !== 4'b0000)
          $display("FAIL drop_hold_c%0d: got grant %b pop %b want 0100 0000", c, grant_o, pop_o);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    do_reset();
    req = 4'b0010; len_a[1] = 8'd5; hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      eval_model();
      n_checks++;
      if (act_vec() !== exp_vec) $display("FAIL rmid_c%0d: got %h want %h", c, act_vec(), exp_vec);
      else n_pass++;
      if (m_owner >= 0 && m_owed == 3) hit = 1'b1;
      else advance();
    end
    n_checks++;
    if (!hit) $display("FAIL rmid_reach: got no remaining=3 want remaining=3 within 20 cycles");
    else n_pass++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (act_vec() !== '0) $display("FAIL rmid_outputs: got %h want %h", act_vec(), {VW{1'b0}});
    else n_pass++;
    @(negedge clk); rst = 1'b0; req = 4'b1111;
    eval_model();
    advance();
    eval_model();
    n_checks++;
    if (grant_o !== 4'b0001 || act_vec() !== exp_vec)
      $display("FAIL rmid_first_grant: got %b want 0001", grant_o);
    else n_pass++;
  endtask

  task automatic test_long();
    int pops;
    bit addr_ok;
    do_reset();
    req = 4'b0001; len_a[0] = 8'd255; adr_a[0] = 8'hA5; pops = 0; addr_ok = 1'b1;
    for (int c = 0; c < 257; c++) begin
      eval_model();
      n_checks++;
      if (act_vec() !== exp_vec) $display("FAIL long_c%0d: got %h want %h", c, act_vec(), exp_vec);
      else n_pass++;
      if (pop_o[0]) pops++;
      if (c >= 2 && flit_address_o !== 8'hA5) addr_ok = 1'b0;
      advance();
    end
    eval_model();
    n_checks++;
    if (pops != 256 || !addr_ok || remaining_o !== 8'd0 || busy_o !== 1'b0)
      $display("FAIL long_summary: got pops %0d addr_ok %0d rem %0d busy %b want 256 1 0 0",
               pops, addr_ok, remaining_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req   = N'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        len_a[k] = AW'($urandom_range(0, 6));
        adr_a[k] = 8'($urandom);
      end
      eval_model();
      n_checks++;
      if (act_vec() !== exp_vec) $display("FAIL rand_c%0d: got %h want %h", c, act_vec(), exp_vec);
      else n_pass++;
      advance();
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin len_a[k] = '0; adr_a[k] = '0; dat_a[k] = $urandom; end
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_req1010();
    test_rr_order();
    test_ready_toggle();
    test_owner_drop();
    test_reset_mid();
    test_long();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
